// File: rtl/func_plot_sched.sv
// rtl/func_plot_sched.sv - pixel sweep scheduler feeding a fixed-latency function pipeline into a framebuffer
// Optional feature macro: FUNC_PLOT_AXES_EN (forces axis pixels, fx==0 or fy==0, to 1).
module func_plot_sched #(
  parameter int CORDW = 8,
  parameter int XRES  = 160,
  parameter int YRES  = 120,
  parameter int LAT   = 5,
  parameter int ADDRW = $clog2(XRES*YRES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic signed [CORDW-1:0] fx,
  output logic signed [CORDW-1:0] fy,
  input  logic                    f_r,
  output logic                    fb_we,
  output logic [ADDRW-1:0]        fb_addr,
  output logic                    fb_colr,
  input  logic                    fb_ready
);
  localparam int DEPTH = LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;
  state_t state, state_n;

  logic [CORDW-1:0] col, row, col_n, row_n;
  logic [ADDRW-1:0] pix_addr;
  logic             last_pix, issue, credit_ok, push, pop, colr_in;
  logic [LAT-1:0]   vsr;
  logic [ADDRW-1:0] asr [LAT];
  logic [CW-1:0]    inflight, fifo_count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [ADDRW-1:0] q_addr [DEPTH];
  logic [DEPTH-1:0] q_colr;

  function automatic logic [CORDW-1:0] coord_x(input logic [CORDW-1:0] c);
    return c - CORDW'(XRES/2);
  endfunction

  function automatic logic [CORDW-1:0] coord_y(input logic [CORDW-1:0] r);
    return CORDW'(YRES/2 - 1) - r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign last_pix  = (col == CORDW'(XRES - 1)) && (row == CORDW'(YRES - 1));
  assign col_n     = (col == CORDW'(XRES - 1)) ? '0 : col + CORDW'(1);
  assign row_n     = (col == CORDW'(XRES - 1)) ? row + CORDW'(1) : row;
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
  assign push      = vsr[LAT-1];
  assign fb_we     = (fifo_count != '0);
  assign pop       = fb_we && fb_ready;
  assign fb_addr   = q_addr[rd_ptr];
  assign fb_colr   = q_colr[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SWEEP;
      S_SWEEP: if (issue && last_pix) state_n = S_DRAIN;
      S_DRAIN: if (pop && fifo_count == CW'(1) && inflight == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      S_SWEEP: begin
        busy  = 1'b1;
        issue = credit_ok;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // fx/fy always show the pixel that would issue this cycle; they only advance on issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      pix_addr <= '0;
      fx       <= '0;
      fy       <= '0;
    end else if (state == S_IDLE && start) begin
      col      <= '0;
      row      <= '0;
      pix_addr <= '0;
      fx       <= coord_x('0);
      fy       <= coord_y('0);
    end else if (issue && !last_pix) begin
      col      <= col_n;
      row      <= row_n;
      pix_addr <= pix_addr + ADDRW'(1);
      fx       <= coord_x(col_n);
      fy       <= coord_y(row_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
      for (int i = 0; i < LAT; i++) asr[i] <= '0;
    end else begin
      vsr[0] <= issue;
      asr[0] <= pix_addr;
      for (int i = 1; i < LAT; i++) begin
        vsr[i] <= vsr[i-1];
        asr[i] <= asr[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vsr[i]);
  end

`ifdef FUNC_PLOT_AXES_EN
  logic [CORDW-1:0] fxsr [LAT];
  logic [CORDW-1:0] fysr [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        fxsr[i] <= '0;
        fysr[i] <= '0;
      end
    end else begin
      fxsr[0] <= fx;
      fysr[0] <= fy;
      for (int i = 1; i < LAT; i++) begin
        fxsr[i] <= fxsr[i-1];
        fysr[i] <= fysr[i-1];
      end
    end
  end

  assign colr_in = (fxsr[LAT-1] == '0 || fysr[LAT-1] == '0) ? 1'b1 : f_r;
`else
  assign colr_in = f_r;
`endif

  // Credit gating guarantees a push never lands on a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      q_colr     <= '0;
      for (int i = 0; i < DEPTH; i++) q_addr[i] <= '0;
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= asr[LAT-1];
        q_colr[wr_ptr] <= colr_in;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end
endmodule

// File: tb/tb_func_plot_sched.sv
// tb/tb_func_plot_sched.sv - self-checking bench for func_plot_sched (scenario/mapping tables + write scoreboard)
module tb_func_plot_sched;
  localparam int CORDW = 8, XRES = 8, YRES = 4, LAT = 5, ADDRW = 5, NPIX = XRES*YRES;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, f_r = 1'b0, fb_ready = 1'b0;
  logic busy, done, fb_we, fb_colr;
  logic signed [CORDW-1:0] fx, fy;
  logic [ADDRW-1:0] fb_addr;

  func_plot_sched #(.CORDW(CORDW), .XRES(XRES), .YRES(YRES), .LAT(LAT), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fx(fx), .fy(fy),
    .f_r(f_r), .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int colr;} exp_t;
  typedef struct {int mode; int exp_writes; int exp_dones; bit force0;} scen_t;
  typedef struct {int addr; int fx; int fy; int colr;} map_t;

  exp_t sb[$];
  exp_t e;
  int passes = 0, checks = 0;
  int cyc = 0, e0 = 1 << 30;
  int writes, dones, first_we, last_we, done_cyc;
  bit cap_en = 1'b0, force0 = 1'b0;
  int cap_fx [NPIX];
  int cap_fy [NPIX];
  int wr_colr [NPIX];
  logic [LAT-1:0] pipe = '0;
  bit r_cur;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_colr(input int a);
    int fxv = a % XRES - XRES/2;
    int fyv = YRES/2 - 1 - a / XRES;
    int r = force0 ? 0 : int'(fxv < fyv);
`ifdef FUNC_PLOT_AXES_EN
    if (fxv == 0 || fyv == 0) r = 1;
`endif
    return r;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Function pipeline model: r = (fx < fy), valid LAT cycles after presentation
  initial forever begin
    @(negedge clk);
    r_cur = force0 ? 1'b0 : (fx < fy);
    @(posedge clk);
    #1;
    pipe = {pipe[LAT-2:0], r_cur};
    f_r  = pipe[LAT-1];
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cap_en && cyc - e0 >= 0 && cyc - e0 < NPIX) begin
        cap_fx[cyc-e0] = int'(fx);
        cap_fy[cyc-e0] = int'(fy);
      end
      if (fb_we && first_we < 0) first_we = cyc;
      if (fb_we && fb_ready) begin
        if (sb.size() == 0) check("unexpected_write_addr", int'(fb_addr), -1);
        else begin
          e = sb.pop_front();
          check("wr_addr", int'(fb_addr), e.addr);
          check("wr_colr", int'(fb_colr), e.colr);
          wr_colr[fb_addr] = int'(fb_colr);
        end
        writes++;
        last_we = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("busy_with_done", int'(busy), 0);
      end
    end
  end

  task automatic prep();
    sb.delete();
    writes = 0; dones = 0; first_we = -1; last_we = -1; done_cyc = -1;
    e0 = 1 << 30;
    for (int a = 0; a < NPIX; a++) sb.push_back('{a, exp_colr(a)});
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_sweep(input scen_t s);
    bit ok = 1'b0;
    force0   = s.force0;
    prep();
    fb_ready = (s.mode == 0 || s.mode == 3);
    cap_en   = (s.mode == 0);
    do_start();
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk); #1;
      if (s.mode == 1 && first_we >= 0 && cyc - first_we == 20 && !fb_ready) begin
        check("stall_fx_pixel7", int'(fx), 3);
        check("stall_fy_pixel7", int'(fy), 1);
        check("stall_no_writes", writes, 0);
        fb_ready = 1'b1;
      end
      if (s.mode == 2) begin
        fb_ready = 1'($urandom_range(0, 1));
        start    = busy && ($urandom_range(0, 7) == 0);
      end
      ok = (dones > 0);
    end
    start = 1'b0;
    if (!ok) check("done_timeout", dones, 1);
    repeat (12) @(posedge clk);
    #1;
    check("writes", writes, s.exp_writes);
    check("dones", dones, s.exp_dones);
    check("sb_left", sb.size(), 0);
    if (s.mode == 0) begin
      check("first_we_latency", first_we - e0, LAT + 1);
      check("burst_span", last_we - first_we, NPIX - 1);
      check("done_after_last", done_cyc - last_we, 1);
    end
    force0 = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk); #2 rst = 1'b1; #1;
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fb_we"}, int'(fb_we), 0);
    check({tag, "_fx"}, int'(fx), 0);
    check({tag, "_fy"}, int'(fy), 0);
    check({tag, "_fb_addr"}, int'(fb_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    scen_t scen [4];
    map_t  maps [6];
    int    n_scen = 3;
    int    ones;
    scen[0] = '{0, NPIX, 1, 1'b0};
    scen[1] = '{1, NPIX, 1, 1'b0};
    scen[2] = '{2, NPIX, 1, 1'b0};
    scen[3] = '{3, NPIX, 1, 1'b1};
`ifdef FUNC_PLOT_AXES_EN
    n_scen = 4;
`endif
    maps[0] = '{0, -4, 1, 1};
    maps[1] = '{2, -2, 1, 1};
    maps[2] = '{7, 3, 1, 0};
    maps[3] = '{22, 2, -1, 0};
    maps[4] = '{25, -3, -2, 1};
    maps[5] = '{31, 3, -2, 0};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fx", int'(fx), 0);
    check("rst_fy", int'(fy), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_colr", int'(fb_colr), 0);
    rst = 1'b0;

    for (int i = 0; i < n_scen; i++) begin
      run_sweep(scen[i]);
      if (scen[i].mode == 0) begin
        for (int m = 0; m < 6; m++) begin
          check($sformatf("map_fx_%0d", maps[m].addr), cap_fx[maps[m].addr], maps[m].fx);
          check($sformatf("map_fy_%0d", maps[m].addr), cap_fy[maps[m].addr], maps[m].fy);
          check($sformatf("map_colr_%0d", maps[m].addr), wr_colr[maps[m].addr], maps[m].colr);
        end
      end
      if (scen[i].mode == 3) begin
        ones = 0;
        for (int a = 0; a < NPIX; a++) ones += wr_colr[a];
        check("axes_ones", ones, 11);
      end
    end

    reset_check("idle_rst");

    prep();
    fb_ready = 1'b1;
    cap_en   = 1'b0;
    do_start();
    repeat (10) @(posedge clk);
    reset_check("sweep_rst");

    run_sweep(scen[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end
endmodule
